fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32 pipeline, directly upstream of the IF/ID register consumers. It owns the PC, issues word requests to a synchronous single-cycle instruction memory, and delivers fetched instructions as `pipelinestages_pkg::if_id_t`. A one-entry skid buffer absorbs the in-flight response during decode stalls. Branch/jump redirects from EX squash all older fetches.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word requests to a
// single-cycle synchronous instruction memory and delivers fetched
// instructions to the IF/ID boundary, with a one-entry skid buffer that
// catches the in-flight response while decode is stalled.
//
// Handshake: imem_req_o/imem_addr_o form a request with no back-pressure.
// The word comes back on imem_rdata_i exactly one cycle later and only for
// that cycle. Downstream, if_id_o.valid marks a live instruction, and
// stall_i=1 means "not taken this cycle, hold it".

package pipelinestages_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

module fetch_stage
    import pipelinestages_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output if_id_t      if_id_o
);

    logic [31:0] pc_q;
    logic        rsp_pending_q;
    logic [31:0] rsp_pc_q;
    logic        skid_valid_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_instr_q;
    if_id_t      if_id_q;

    logic [31:0] fetch_addr;
    logic        issue;
    logic        unused_ok;

    // The low two bits of a redirect target carry no meaning for word fetch.
    assign unused_ok = ^redirect_pc_i[1:0];

    // Redirect target takes precedence over the sequential PC.
    assign fetch_addr = redirect_i ? {redirect_pc_i[31:2], 2'b00} : pc_q;

    // While stalled, only fetch when nothing is in flight and the skid is
    // empty, so a response can never find both IF/ID held and the skid full.
    assign issue = redirect_i | ~stall_i | (~skid_valid_q & ~rsp_pending_q);

    assign imem_req_o  = issue & ~rst;
    assign imem_addr_o = fetch_addr;
    assign if_id_o     = if_id_q;

    // PC advance and tracking of the request whose data arrives next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pending_q <= 1'b0;
            rsp_pc_q      <= 32'h0;
        end else if (issue) begin
            pc_q          <= fetch_addr + 32'd4;
            rsp_pending_q <= 1'b1;
            rsp_pc_q      <= fetch_addr;
        end else begin
            rsp_pending_q <= 1'b0;
        end
    end

    // IF/ID register and skid buffer: squash on redirect, park the arriving
    // word during a stall, drain the skid first once the stall lifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            if_id_q      <= '0;
        end else if (redirect_i) begin
            skid_valid_q  <= 1'b0;
            if_id_q.valid <= 1'b0;
        end else if (stall_i) begin
            if (rsp_pending_q) begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= rsp_pc_q;
                skid_instr_q <= imem_rdata_i;
            end
        end else if (skid_valid_q) begin
            if_id_q.valid <= 1'b1;
            if_id_q.pc    <= skid_pc_q;
            if_id_q.instr <= skid_instr_q;
            skid_valid_q  <= rsp_pending_q;
            skid_pc_q     <= rsp_pc_q;
            skid_instr_q  <= imem_rdata_i;
        end else if (rsp_pending_q) begin
            if_id_q.valid <= 1'b1;
            if_id_q.pc    <= rsp_pc_q;
            if_id_q.instr <= imem_rdata_i;
        end else begin
            if_id_q.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: synchronous memory model, directed scenarios then
// random stall/redirect traffic. Every issued fetch pushes its expected
// {pc, instr} into a queue; the monitor pops on each consumed output.

module tb_fetch_stage;
    import pipelinestages_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    if_id_t      if_id_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_req_cyc = -1;
    int first_valid_cyc = -1;

    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [31:0] model_pc;
    logic [31:0] ea;
    logic        p_hold = 1'b0;
    logic        p_redir = 1'b0;
    if_id_t      p_ifid;
    logic        seq_mode = 1'b0;
    logic        have_last = 1'b0;
    logic [31:0] last_pc;

    // clock / reset
    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .if_id_o(if_id_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Single-cycle synchronous memory; garbage when no request was made.
    always @(posedge clk) imem_rdata_i <= imem_req_o ? mem_word(imem_addr_o) : $urandom;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            p_hold  = 1'b0;
            p_redir = 1'b0;
        end else begin
            if (p_hold) check("stall_freeze", if_id_o, p_ifid);
            if (p_redir) check("redirect_bubble", if_id_o.valid, 1'b0);
            if (if_id_o.valid && !stall_i && !redirect_i) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (seq_mode && have_last) check("emit_seq", if_id_o.pc, last_pc + 32'd4);
                last_pc   = if_id_o.pc;
                have_last = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL emit_unexpected actual_pc=%h required=none", if_id_o.pc);
                end else begin
                    e = exp_q.pop_front();
                    check("emit_pc_instr", {if_id_o.pc, if_id_o.instr}, e);
                end
            end
            if (redirect_i) exp_q.delete();
            if (redirect_i || !stall_i) check("req_required", imem_req_o, 1'b1);
            if (imem_req_o) begin
                ea = redirect_i ? {redirect_pc_i[31:2], 2'b00} : model_pc;
                check("fetch_addr", imem_addr_o, ea);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                exp_q.push_back({ea, mem_word(ea)});
                model_pc = ea + 32'd4;
            end
            p_hold  = stall_i && !redirect_i;
            p_ifid  = if_id_o;
            p_redir = redirect_i;
        end
    end

    // driver tasks
    task automatic drive(input logic s, input logic r, input logic [31:0] t);
        @(posedge clk);
        #1;
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = t;
    endtask

    task automatic do_reset_async();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_if_id", if_id_o, 65'h0);
        check("rst_req", imem_req_o, 1'b0);
        exp_q.delete();
        model_pc        = RST_PC;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        stall_i         = 1'b0;
        redirect_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        model_pc      = RST_PC;
        #12;
        check("init_if_id", if_id_o, 65'h0);
        check("init_req", imem_req_o, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sequential fetch from RESET_PC, no stalls.
        repeat (10) drive(1'b0, 1'b0, 32'h0);
        check("first_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);

        // Three-cycle stall with a response in flight.
        seq_mode  = 1'b1;
        have_last = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 32'h0);
        repeat (4) drive(1'b0, 1'b0, 32'h0);
        seq_mode = 1'b0;

        // Fill the skid, then redirect while still stalled.
        repeat (2) drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0203);
        repeat (5) drive(1'b0, 1'b0, 32'h0);

        // Redirect near the top of the address space; fetch wraps to 0.
        drive(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6) drive(1'b0, 1'b0, 32'h0);

        // Async reset during a stall with the skid full.
        repeat (2) drive(1'b1, 1'b0, 32'h0);
        do_reset_async();
        repeat (8) drive(1'b0, 1'b0, 32'h0);
        check("reset_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);

        // Alternating stall for 20 cycles.
        seq_mode  = 1'b1;
        have_last = 1'b0;
        for (int i = 0; i < 20; i++) drive(i[0], 1'b0, 32'h0);
        repeat (3) drive(1'b0, 1'b0, 32'h0);
        seq_mode = 1'b0;

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset_async();
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom);
        end

        // Drain: with no stalls only the two newest fetches remain in flight.
        repeat (5) drive(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        check("drain_depth", exp_q.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
